aegnn_stage_sched: RTL

//  Top-level stage sequencer for the AEGNN accelerator. Accepts events one at a time and runs

---
 rtl/aegnn_stage_sched_pkg.sv | 32 +++
 rtl/aegnn_stage_sched_if.sv | 43 ++++
 rtl/aegnn_stage_watchdog.sv | 36 +++
 rtl/aegnn_stage_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/aegnn_stage_sched_pkg.sv
// Shared types and default sizing for the AEGNN stage scheduler slice.
// The event layout matches one URAM word of the input event FIFO.
package aegnn_stage_sched_pkg;

  localparam int URAM_WIDTH    = 72;
  localparam int NUM_GC_LAYERS = 4;
  localparam int BATCH_EVENTS  = 1024;
  localparam int SCHED_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GRAPH_BUILD = 3'd1,
    GRAPH_CONV  = 3'd2,
    MAXP        = 3'd3,
    FC          = 3'd4
  } func_stage_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rsvd;
    logic        polarity;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] ts;
  } event_s;

  // Counter/index width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aegnn_stage_sched_if.sv
// Event-FIFO and engine start/done bundle for the stage scheduler.
// master = scheduler side, slave = FIFO / compute-engine side.
interface aegnn_stage_sched_if #(
  parameter int NUM_LAYERS   = aegnn_stage_sched_pkg::NUM_GC_LAYERS,
  parameter int BATCH_EVENTS = aegnn_stage_sched_pkg::BATCH_EVENTS
);
  import aegnn_stage_sched_pkg::*;

  localparam int LAYER_W = min1_clog2(NUM_LAYERS);
  localparam int CNT_W   = min1_clog2(BATCH_EVENTS + 1);

  logic               ev_valid;
  logic               ev_ready;
  event_s             ev_data;
  logic               flush;
  event_s             cur_ev;
  func_stage_e        stage;
  logic               gb_start;
  logic               gb_done;
  logic               gc_start;
  logic [LAYER_W-1:0] gc_layer;
  logic               gc_done;
  logic               mp_start;
  logic               mp_done;
  logic               fc_start;
  logic               fc_done;
  logic               frame_done;
  logic [CNT_W-1:0]   ev_cnt;
  logic               err_timeout;

  modport master (
    input  ev_valid, ev_data, flush, gb_done, gc_done, mp_done, fc_done,
    output ev_ready, cur_ev, stage, gb_start, gc_start, gc_layer, mp_start,
           fc_start, frame_done, ev_cnt, err_timeout
  );

  modport slave (
    output ev_valid, ev_data, flush, gb_done, gc_done, mp_done, fc_done,
    input  ev_ready, cur_ev, stage, gb_start, gc_start, gc_layer, mp_start,
           fc_start, frame_done, ev_cnt, err_timeout
  );

endinterface

// File: rtl/aegnn_stage_watchdog.sv
// Per-stage cycle counter; expired flags the TIMEOUT_CYC-th cycle spent in one stage.
// TIMEOUT_CYC = 0 disables expiry; the counter saturates instead of wrapping.
module aegnn_stage_watchdog #(
  parameter int TIMEOUT_CYC = aegnn_stage_sched_pkg::SCHED_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic stage_entry,
  input  logic active,
  output logic expired
);
  import aegnn_stage_sched_pkg::*;

  localparam int              WD_W    = min1_clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] CNT_MAX = '1;
  localparam logic [WD_W-1:0] LIMIT   = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic            ENABLED = (TIMEOUT_CYC > 0);

  logic [WD_W-1:0] cnt_r;

  // Cycles already spent in the current stage; cleared on the edge that enters a stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (stage_entry || !active) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = ENABLED && active && (cnt_r == LIMIT);

endmodule

// File: rtl/aegnn_stage_sched.sv
// Stage sequencer: GRAPH_BUILD then NUM_LAYERS x GRAPH_CONV per event,
// then MAXP and FC once a frame is complete or a flush is pending.
module aegnn_stage_sched #(
  parameter int NUM_LAYERS   = aegnn_stage_sched_pkg::NUM_GC_LAYERS,
  parameter int BATCH_EVENTS = aegnn_stage_sched_pkg::BATCH_EVENTS,
  parameter int TIMEOUT_CYC  = aegnn_stage_sched_pkg::SCHED_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  aegnn_stage_sched_if.master bus
);
  import aegnn_stage_sched_pkg::*;

  localparam int                 LAYER_W    = min1_clog2(NUM_LAYERS);
  localparam int                 CNT_W      = min1_clog2(BATCH_EVENTS + 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0]   FRAME_LEN  = CNT_W'(BATCH_EVENTS);

  func_stage_e        stage_r, stage_s;
  event_s             cur_ev_r, cur_ev_s;
  logic [LAYER_W-1:0] gc_layer_r, gc_layer_s;
  logic [CNT_W-1:0]   ev_cnt_r, ev_cnt_s;
  logic               flush_pend_r, flush_pend_s, flush_clr_s;
  logic               err_timeout_r, err_timeout_s;
  logic               gb_start_r, gb_start_s, gc_start_r, gc_start_s;
  logic               mp_start_r, mp_start_s, fc_start_r, fc_start_s;
  logic               frame_done_r, frame_done_s;
  logic               stage_entry_s, wd_expired_s;

  aegnn_stage_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .stage_entry(stage_entry_s),
    .active     (stage_r != IDLE),
    .expired    (wd_expired_s)
  );

  // Next-state and next-output decode; every start pulse is raised on the entering edge.
  always_comb begin
    stage_s       = stage_r;
    cur_ev_s      = cur_ev_r;
    gc_layer_s    = gc_layer_r;
    ev_cnt_s      = ev_cnt_r;
    err_timeout_s = err_timeout_r;
    flush_clr_s   = 1'b0;
    gb_start_s    = 1'b0;
    gc_start_s    = 1'b0;
    mp_start_s    = 1'b0;
    fc_start_s    = 1'b0;
    frame_done_s  = 1'b0;
    if (wd_expired_s) begin
      stage_s       = IDLE;
      err_timeout_s = 1'b1;
      ev_cnt_s      = '0;
      flush_clr_s   = 1'b1;
    end else begin
      case (stage_r)
        IDLE: begin
          if (flush_pend_r) begin
            if (ev_cnt_r != '0) begin
              stage_s    = MAXP;
              mp_start_s = 1'b1;
            end else begin
              flush_clr_s = 1'b1;
            end
          end else if (bus.ev_valid && bus.ev_data.valid) begin
            cur_ev_s   = bus.ev_data;
            stage_s    = GRAPH_BUILD;
            gb_start_s = 1'b1;
          end else begin
            stage_s = IDLE;
          end
        end
        GRAPH_BUILD: begin
          if (bus.gb_done) begin
            stage_s    = GRAPH_CONV;
            gc_layer_s = '0;
            gc_start_s = 1'b1;
          end else begin
            stage_s = GRAPH_BUILD;
          end
        end
        GRAPH_CONV: begin
          if (bus.gc_done && (gc_layer_r != LAST_LAYER)) begin
            gc_layer_s = gc_layer_r + 1'b1;
            gc_start_s = 1'b1;
          end else if (bus.gc_done) begin
            ev_cnt_s = ev_cnt_r + 1'b1;
            if (((ev_cnt_r + 1'b1) == FRAME_LEN) || flush_pend_r) begin
              stage_s    = MAXP;
              mp_start_s = 1'b1;
            end else begin
              stage_s = IDLE;
            end
          end else begin
            stage_s = GRAPH_CONV;
          end
        end
        MAXP: begin
          if (bus.mp_done) begin
            stage_s    = FC;
            fc_start_s = 1'b1;
          end else begin
            stage_s = MAXP;
          end
        end
        FC: begin
          if (bus.fc_done) begin
            stage_s      = IDLE;
            frame_done_s = 1'b1;
            ev_cnt_s     = '0;
            flush_clr_s  = 1'b1;
          end else begin
            stage_s = FC;
          end
        end
        default: begin
          stage_s = IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the same cycle as a clear still leaves a request pending.
  assign flush_pend_s  = (flush_pend_r && !flush_clr_s) || bus.flush;
  assign stage_entry_s = gb_start_s | gc_start_s | mp_start_s | fc_start_s;

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r       <= IDLE;
      cur_ev_r      <= '0;
      gc_layer_r    <= '0;
      ev_cnt_r      <= '0;
      flush_pend_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      gb_start_r    <= 1'b0;
      gc_start_r    <= 1'b0;
      mp_start_r    <= 1'b0;
      fc_start_r    <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      stage_r       <= stage_s;
      cur_ev_r      <= cur_ev_s;
      gc_layer_r    <= gc_layer_s;
      ev_cnt_r      <= ev_cnt_s;
      flush_pend_r  <= flush_pend_s;
      err_timeout_r <= err_timeout_s;
      gb_start_r    <= gb_start_s;
      gc_start_r    <= gc_start_s;
      mp_start_r    <= mp_start_s;
      fc_start_r    <= fc_start_s;
      frame_done_r  <= frame_done_s;
    end
  end

  assign bus.ev_ready    = (stage_r == IDLE) && !flush_pend_r && !rst;
  assign bus.cur_ev      = cur_ev_r;
  assign bus.stage       = stage_r;
  assign bus.gb_start    = gb_start_r;
  assign bus.gc_start    = gc_start_r;
  assign bus.gc_layer    = gc_layer_r;
  assign bus.mp_start    = mp_start_r;
  assign bus.fc_start    = fc_start_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.ev_cnt      = ev_cnt_r;
  assign bus.err_timeout = err_timeout_r;

endmodule
